boot_loader: RTL and testbench

Program loader upstream of the CPU core. It receives a byte stream carrying a length header, 16-bit instruction words and an XOR checksum, and writes the words into the instruction ROM through its write port. It holds the core in reset until the image is loaded and verified, then releases it. A reload request returns the core to reset and accepts a new image.

---
 rtl/boot_loader_if.sv | 30 +++
 rtl/boot_loader.sv | 131 +++++++++++++
 tb/tb_boot_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream input and ROM write port of the boot loader.
// The loader sits on the slave side. The stream source and the ROM write port sit on the master side.
interface boot_loader_if #(
    parameter int ROM_AWIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  rom_wr;
    logic [ROM_AWIDTH-1:0] rom_waddr;
    logic [15:0]           rom_wdata;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output rom_wr,
        output rom_waddr,
        output rom_wdata
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  rom_wr,
        input  rom_waddr,
        input  rom_wdata
    );
endinterface

// File: rtl/boot_loader.sv
// Program loader: parses a length/words/checksum byte stream and writes the words
// into the instruction ROM. It holds the core in reset until the image verifies.
module boot_loader #(
    parameter int ROM_AWIDTH    = 8,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    boot_loader_if.slave      bus,
    input  logic              reload,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [8:0]        words_loaded
);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CHK,
        ST_WAIT,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [3:0]            DELAY_INIT = 4'(RELEASE_DELAY);
    localparam logic [ROM_AWIDTH-1:0] ADDR_ONE   = ROM_AWIDTH'(1);

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic [8:0]            word_count;
    logic [7:0]            hi_byte;
    logic [7:0]            checksum;
    logic [3:0]            delay_cnt;
    logic [ROM_AWIDTH-1:0] waddr;

    // Next-state decode. in_ready is registered from this value, so it already matches the state it will face.
    always_comb begin
        accept     = bus.in_valid && bus.in_ready;
        next_state = state;
        case (state)
            ST_LEN:   if (accept) next_state = ST_HI;
            ST_HI:    if (accept) next_state = ST_LO;
            ST_LO:    if (accept) next_state = ((words_loaded + 9'd1) == word_count) ? ST_CHK : ST_HI;
            ST_CHK:   if (accept) next_state = (bus.in_data == checksum) ? ST_WAIT : ST_ERROR;
            ST_WAIT:  if (delay_cnt == 4'd0) next_state = ST_RUN;
            ST_RUN:   if (reload) next_state = ST_LEN;
            ST_ERROR: if (reload) next_state = ST_LEN;
            default:  next_state = ST_LEN;
        endcase
    end

    // Loader FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_LEN;
            bus.in_ready  <= 1'b0;
            bus.rom_wr    <= 1'b0;
            bus.rom_waddr <= '0;
            bus.rom_wdata <= '0;
            cpu_rst       <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_loaded  <= '0;
            word_count    <= '0;
            hi_byte       <= '0;
            checksum      <= '0;
            delay_cnt     <= '0;
            waddr         <= '0;
        end else begin
            state        <= next_state;
            bus.in_ready <= (next_state inside {ST_LEN, ST_HI, ST_LO, ST_CHK});
            bus.rom_wr   <= 1'b0;
            case (state)
                ST_LEN: begin
                    if (accept) begin
                        word_count   <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                        words_loaded <= '0;
                        waddr        <= '0;
                        checksum     <= '0;
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        hi_byte  <= bus.in_data;
                        checksum <= checksum ^ bus.in_data;
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        checksum      <= checksum ^ bus.in_data;
                        bus.rom_wr    <= 1'b1;
                        bus.rom_waddr <= waddr;
                        bus.rom_wdata <= {hi_byte, bus.in_data};
                        waddr         <= waddr + ADDR_ONE;
                        words_loaded  <= words_loaded + 9'd1;
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        if (bus.in_data == checksum) begin
                            delay_cnt <= DELAY_INIT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (delay_cnt == 4'd0) begin
                        cpu_rst <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt - 4'd1;
                    end
                end
                ST_RUN, ST_ERROR: begin
                    if (reload) begin
                        cpu_rst      <= 1'b0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a table of image loads plus hand-written
// reload and mid-load reset sequences. Expected ROM writes go through a scoreboard queue.
module tb_boot_loader;

    localparam int RELEASE_DELAY = 4;

    typedef struct {
        string       name;
        int          n;
        logic [15:0] w0;
        logic [15:0] step;
        bit          use_given_chk;
        logic [7:0]  given_chk;
        bit          gaps;
        bit          exp_error;
        logic [8:0]  exp_words;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       reload = 1'b0;
    logic       cpu_rst;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    logic prev_wr = 1'b0;

    boot_loader_if #(.ROM_AWIDTH(8)) bus ();

    boot_loader #(
        .ROM_AWIDTH(8),
        .RELEASE_DELAY(RELEASE_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .reload(reload),
        .cpu_rst(cpu_rst),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Guard against a hung bench.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every ROM write must match the oldest expected write, and each strobe lasts one cycle.
    always @(negedge clk) begin
        wr_t e;
        if (bus.rom_wr === 1'b1) begin
            check_output("rom_wr_single_cycle", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got write addr 0x%0h data 0x%0h, expected no write",
                         bus.rom_waddr, bus.rom_wdata);
            end else begin
                e = exp_q.pop_front();
                check_output("rom_waddr", {24'd0, bus.rom_waddr}, {24'd0, e.addr});
                check_output("rom_wdata", {16'd0, bus.rom_wdata}, {16'd0, e.data});
            end
        end
        prev_wr = bus.rom_wr;
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"},     {31'd0, bus.in_ready}, 32'd0);
        check_output({tag, "_rom_wr"},       {31'd0, bus.rom_wr},   32'd0);
        check_output({tag, "_rom_waddr"},    {24'd0, bus.rom_waddr}, 32'd0);
        check_output({tag, "_rom_wdata"},    {16'd0, bus.rom_wdata}, 32'd0);
        check_output({tag, "_cpu_rst"},      {31'd0, cpu_rst},      32'd0);
        check_output({tag, "_done"},         {31'd0, done},         32'd0);
        check_output({tag, "_error"},        {31'd0, error},        32'd0);
        check_output({tag, "_words_loaded"}, {23'd0, words_loaded}, 32'd0);
    endtask

    // Drive one byte and hold it until the handshake edge has passed. The task is called and returns at a negedge.
    task automatic apply_stimulus(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hEE;
            repeat (g) @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        forever begin
            logic ready_now;
            ready_now = bus.in_ready;
            @(negedge clk);
            if (ready_now) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake_timeout: in_ready stayed 0 for byte 0x%0h, expected 1", b);
                break;
            end
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_output("reload_cpu_rst",      {31'd0, cpu_rst},      32'd0);
        check_output("reload_in_ready",     {31'd0, bus.in_ready}, 32'd1);
        check_output("reload_done",         {31'd0, done},         32'd0);
        check_output("reload_error",        {31'd0, error},        32'd0);
        check_output("reload_words_loaded", {23'd0, words_loaded}, 32'd0);
    endtask

    task automatic run_vector(input vec_t v);
        logic [7:0]  chk;
        logic [15:0] w;
        wr_t         e;
        chk = 8'h00;
        apply_stimulus((v.n == 256) ? 8'h00 : 8'(v.n), v.gaps);
        for (int i = 0; i < v.n; i++) begin
            w = v.w0 + 16'(i) * v.step;
            e.addr = 8'(i);
            e.data = w;
            exp_q.push_back(e);
            apply_stimulus(w[15:8], v.gaps);
            apply_stimulus(w[7:0], v.gaps);
            chk = chk ^ w[15:8] ^ w[7:0];
        end
        check_output({v.name, "_words_before_chk"}, {23'd0, words_loaded}, {23'd0, v.exp_words});
        check_output({v.name, "_cpu_rst_loading"}, {31'd0, cpu_rst}, 32'd0);
        if (v.use_given_chk) chk = v.given_chk;
        apply_stimulus(chk, v.gaps);
        bus.in_valid = 1'b0;
        if (!v.exp_error) begin
            check_output({v.name, "_cpu_rst_at_k"}, {31'd0, cpu_rst}, 32'd0);
            repeat (RELEASE_DELAY) begin
                @(negedge clk);
                check_output({v.name, "_cpu_rst_wait"},  {31'd0, cpu_rst},      32'd0);
                check_output({v.name, "_in_ready_wait"}, {31'd0, bus.in_ready}, 32'd0);
            end
            @(negedge clk);
            check_output({v.name, "_cpu_rst_release"}, {31'd0, cpu_rst}, 32'd1);
            check_output({v.name, "_done"},            {31'd0, done},    32'd1);
            check_output({v.name, "_error_clear"},     {31'd0, error},   32'd0);
        end else begin
            check_output({v.name, "_error"},    {31'd0, error},        32'd1);
            check_output({v.name, "_cpu_rst"},  {31'd0, cpu_rst},      32'd0);
            check_output({v.name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
            check_output({v.name, "_done"},     {31'd0, done},         32'd0);
            bus.in_data  = 8'h5A;
            bus.in_valid = 1'b1;
            repeat (5) @(negedge clk);
            bus.in_valid = 1'b0;
            check_output({v.name, "_error_held"},    {31'd0, error},        32'd1);
            check_output({v.name, "_cpu_rst_held"},  {31'd0, cpu_rst},      32'd0);
            check_output({v.name, "_in_ready_held"}, {31'd0, bus.in_ready}, 32'd0);
            check_output({v.name, "_words_held"},    {23'd0, words_loaded}, {23'd0, v.exp_words});
        end
        check_output({v.name, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Main test sequence.
    initial begin
        vec_t vecs[5];
        wr_t  e;

        vecs[0] = '{name: "nominal",  n: 2,   w0: 16'h1234, step: 16'h9999, use_given_chk: 1'b1,
                    given_chk: 8'h40, gaps: 1'b0, exp_error: 1'b0, exp_words: 9'd2};
        vecs[1] = '{name: "bad_chk",  n: 2,   w0: 16'h1234, step: 16'h9999, use_given_chk: 1'b1,
                    given_chk: 8'h41, gaps: 1'b0, exp_error: 1'b1, exp_words: 9'd2};
        vecs[2] = '{name: "gaps",     n: 2,   w0: 16'h1234, step: 16'h9999, use_given_chk: 1'b1,
                    given_chk: 8'h40, gaps: 1'b1, exp_error: 1'b0, exp_words: 9'd2};
        vecs[3] = '{name: "full",     n: 256, w0: 16'h0000, step: 16'h0001, use_given_chk: 1'b0,
                    given_chk: 8'h00, gaps: 1'b0, exp_error: 1'b0, exp_words: 9'd256};
        vecs[4] = '{name: "reload1",  n: 1,   w0: 16'h00FF, step: 16'h0000, use_given_chk: 1'b1,
                    given_chk: 8'hFF, gaps: 1'b0, exp_error: 1'b0, exp_words: 9'd1};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst          = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst = 1'b1;
        check_output("in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check_output("in_ready_after_edge", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            if (i > 0) pulse_reload();
            run_vector(vecs[i]);
        end

        // Reset mid-load: stop after the HI byte of word 1, with an ignored reload on the way.
        pulse_reload();
        apply_stimulus(8'h02, 1'b0);
        e.addr = 8'h00;
        e.data = 16'h1234;
        exp_q.push_back(e);
        apply_stimulus(8'h12, 1'b0);
        apply_stimulus(8'h34, 1'b0);
        apply_stimulus(8'hAB, 1'b0);
        bus.in_valid = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_output("midload_reload_ignored_ready", {31'd0, bus.in_ready}, 32'd1);
        check_output("midload_words",                {23'd0, words_loaded}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        check_output("midload_writes_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        run_vector(vecs[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
